// File: rtl/pipeline_pkg.sv
// Shared pipeline types: fetch sequencer states and default fetch PC vectors.
package pipeline_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC_DEF  = 32'h0000_0100;

endpackage

// File: rtl/fetch_ctrl_pc_next_sel.sv
// Next-PC priority mux: redirect (or trap) > hold > sequential advance.
module pc_next_sel #(
  parameter int              XLEN    = 32,
  parameter logic [XLEN-1:0] TRAP_PC = XLEN'(32'h0000_0100)
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] pc_target,
  input  logic            redirect,
  input  logic            hold,
  input  logic            trap_en,
  output logic [XLEN-1:0] pc_next,
  output logic            misalign
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  // Low PC bits are masked on every load so the PC stays word-aligned.
  always_comb begin
    pc_next  = pc;
    misalign = 1'b0;
    if (redirect) begin
      if (trap_en && (pc_target[1:0] != 2'b00)) begin
        pc_next  = TRAP_PC;
        misalign = 1'b1;
      end else begin
        pc_next = pc_target & ALIGN_MASK;
      end
    end else if (!hold) begin
      pc_next = pc_plus4 & ALIGN_MASK;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: BOOT (imem loader owns memory) -> FETCH <-> HALT, owns the fetch PC.
// Build option: define MISALIGN_TRAP_EN to trap misaligned redirects to TRAP_PC.
module fetch_ctrl
  import pipeline_pkg::*;
#(
  parameter int                XLEN       = 32,
  parameter int                ADDR_WIDTH = 8,
  parameter logic [XLEN-1:0]   RESET_PC   = XLEN'(RESET_PC_DEF),
  parameter logic [XLEN-1:0]   TRAP_PC    = XLEN'(TRAP_PC_DEF)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [XLEN-1:0]       load_data,
  input  logic                  load_done,
  output logic                  load_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [XLEN-1:0]       imem_wdata,
  input  logic                  StallF,
  input  logic                  PCSrcE,
  input  logic [XLEN-1:0]       PCTargetE,
  input  logic [XLEN-1:0]       PCPlus4F,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic [XLEN-1:0]       PC,
  output logic                  fetch_valid,
  output logic [ADDR_WIDTH:0]   loaded_cnt,
  output logic                  misalign_err
);

  localparam logic [ADDR_WIDTH:0] CNT_MAX = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

`ifdef MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc_next;
  logic            misalign;

  // halt_req also freezes the PC, unless a redirect lands in the same cycle.
  pc_next_sel #(
    .XLEN    (XLEN),
    .TRAP_PC (TRAP_PC)
  ) u_pc_next_sel (
    .pc        (PC),
    .pc_plus4  (PCPlus4F),
    .pc_target (PCTargetE),
    .redirect  (PCSrcE),
    .hold      (StallF | halt_req),
    .trap_en   (TRAP_EN),
    .pc_next   (pc_next),
    .misalign  (misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    load_ready  = 1'b0;
    imem_we     = 1'b0;
    fetch_valid = 1'b0;
    case (state)
      BOOT: begin
        load_ready = 1'b1;
        imem_we    = load_valid;
        if (load_done) state_nxt = FETCH;
      end
      FETCH: begin
        fetch_valid = 1'b1;
        if (halt_req) state_nxt = HALT;
      end
      HALT: begin
        if (resume && !halt_req) state_nxt = FETCH;
      end
      default: state_nxt = BOOT;
    endcase
  end

  assign imem_waddr = load_addr;
  assign imem_wdata = load_data;

  // PC only moves in FETCH; BOOT is entered only through reset, so it sits at RESET_PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC           <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= (state == FETCH) && misalign;
      if (state == FETCH) PC <= pc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loaded_cnt <= '0;
    end else if (imem_we && (loaded_cnt != CNT_MAX)) begin
      loaded_cnt <= loaded_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed plan plus randomized traffic vs a reference model.
module tb_fetch_ctrl;

  localparam int XLEN = 32;
  localparam int AW   = 8;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            load_valid;
  logic [AW-1:0]   load_addr;
  logic [XLEN-1:0] load_data;
  logic            load_done;
  logic            load_ready;
  logic            imem_we;
  logic [AW-1:0]   imem_waddr;
  logic [XLEN-1:0] imem_wdata;
  logic            StallF;
  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic [XLEN-1:0] PCPlus4F;
  logic            halt_req;
  logic            resume;
  logic [XLEN-1:0] PC;
  logic            fetch_valid;
  logic [AW:0]     loaded_cnt;
  logic            misalign_err;

  fetch_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_valid   (load_valid),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .load_done    (load_done),
    .load_ready   (load_ready),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .StallF       (StallF),
    .PCSrcE       (PCSrcE),
    .PCTargetE    (PCTargetE),
    .PCPlus4F     (PCPlus4F),
    .halt_req     (halt_req),
    .resume       (resume),
    .PC           (PC),
    .fetch_valid  (fetch_valid),
    .loaded_cnt   (loaded_cnt),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0=boot, 1=fetching, 2=halted
  int              m_mode;
  logic [XLEN-1:0] m_pc;
  int              m_cnt;
  bit              m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = 32'h0;
    m_cnt  = 0;
    m_err  = 1'b0;
  endtask

  task automatic check_outputs(input bit lv);
    chk("pc", 64'(PC), 64'(m_pc));
    chk("fetch_valid", 64'(fetch_valid), 64'(m_mode == 1));
    chk("load_ready", 64'(load_ready), 64'(m_mode == 0));
    chk("imem_we", 64'(imem_we), 64'((m_mode == 0) && lv));
    chk("loaded_cnt", 64'(loaded_cnt), 64'(m_cnt));
    chk("misalign_err", 64'(misalign_err), 64'(m_err));
    if (m_mode == 0 && lv) begin
      chk("imem_waddr", 64'(imem_waddr), 64'(load_addr));
      chk("imem_wdata", 64'(imem_wdata), 64'(load_data));
    end
  endtask

  // One clock: drive after negedge, check, clock, advance the model.
  task automatic step(input bit lv, input logic [AW-1:0] la, input logic [XLEN-1:0] ld,
                      input bit done, input bit stall, input bit src,
                      input logic [XLEN-1:0] tgt, input bit hreq, input bit res);
    load_valid = lv;  load_addr = la;  load_data = ld;  load_done = done;
    StallF = stall;   PCSrcE = src;    PCTargetE = tgt;
    halt_req = hreq;  resume = res;    PCPlus4F = m_pc + 32'd4;
    #1;
    check_outputs(lv);
    @(posedge clk);
    m_err = 1'b0;
    case (m_mode)
      0: begin
        if (lv && m_cnt < (1 << AW)) m_cnt++;
        if (done) m_mode = 1;
      end
      1: begin
        if (src) begin
          if (TRAP && tgt[1:0] != 2'b00) begin
            m_pc  = 32'h100;
            m_err = 1'b1;
          end else begin
            m_pc = tgt - XLEN'(tgt % 4);
          end
        end else if (!(stall || hreq)) begin
          m_pc = m_pc + 32'd4;
        end
        if (hreq) m_mode = 2;
      end
      default: if (res && !hreq) m_mode = 1;
    endcase
    @(negedge clk);
  endtask

  task automatic idle(); step(0, '0, '0, 0, 0, 0, '0, 0, 0); endtask
  task automatic redir(input logic [XLEN-1:0] t, input bit stall);
    step(0, '0, '0, 0, stall, 1, t, 0, 0);
  endtask

  // Asynchronous reset asserted between clock edges, checked before any edge.
  task automatic async_reset();
    load_valid = 0; load_done = 0; StallF = 0; PCSrcE = 0; halt_req = 0; resume = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_pc", 64'(PC), 64'h0);
    chk("rst_cnt", 64'(loaded_cnt), 64'h0);
    chk("rst_fetch_valid", 64'(fetch_valid), 64'h0);
    chk("rst_load_ready", 64'(load_ready), 64'h1);
    check_outputs(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    load_valid = 0; load_addr = '0; load_data = '0; load_done = 0;
    StallF = 0; PCSrcE = 0; PCTargetE = '0; PCPlus4F = '0; halt_req = 0; resume = 0;
    model_reset();
    #3;
    chk("reset_pc", 64'(PC), 64'h0);
    chk("reset_cnt", 64'(loaded_cnt), 64'h0);
    chk("reset_load_ready", 64'(load_ready), 64'h1);
    chk("reset_we", 64'(imem_we), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Boot load of three words, then release to fetch
    step(1, 8'd0, 32'h13, 0, 0, 0, '0, 0, 0);
    step(1, 8'd1, 32'h93, 0, 0, 0, '0, 0, 0);
    step(1, 8'd2, 32'h113, 0, 0, 0, '0, 0, 0);
    chk("boot_cnt3", 64'(loaded_cnt), 64'd3);
    step(0, '0, '0, 1, 0, 0, '0, 0, 0);
    #1;
    chk("fetch_entry_valid", 64'(fetch_valid), 64'h1);
    chk("fetch_entry_pc", 64'(PC), 64'h0);

    // Sequential fetch with a stall on the second cycle: 0,4,4,8
    idle();
    step(0, '0, '0, 0, 1, 0, '0, 0, 0);
    chk("stall_hold", 64'(PC), 64'h4);
    idle();
    chk("seq_pc8", 64'(PC), 64'h8);

    // Redirect beats stall
    redir(32'h40, 1'b1);
    chk("redir_over_stall", 64'(PC), 64'h40);

    // Halt at 0x8, ignore redirects, halt+resume together stays halted
    redir(32'h8, 1'b0);
    step(0, '0, '0, 0, 0, 0, '0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, '0, '0, 0, i[0], ~i[0], 32'h80, (i == 3), (i == 3));
      chk("halt_pc", 64'(PC), 64'h8);
      chk("halt_valid", 64'(fetch_valid), 64'h0);
    end
    step(0, '0, '0, 0, 0, 0, '0, 0, 1);
    chk("resume_pc", 64'(PC), 64'h8);
    idle();
    chk("resume_next_pc", 64'(PC), 64'hC);

    // Redirect in the same cycle as halt_req is taken before halting
    step(0, '0, '0, 0, 1, 1, 32'h64, 1, 0);
    chk("halt_redir_pc", 64'(PC), 64'h64);
    step(0, '0, '0, 0, 0, 0, '0, 0, 1);

    // Misaligned redirect
    redir(32'h42, 1'b0);
    chk("misalign_pc", 64'(PC), TRAP ? 64'h100 : 64'h40);
    chk("misalign_pulse", 64'(misalign_err), 64'(TRAP));
    idle();
    chk("misalign_clear", 64'(misalign_err), 64'h0);

    // PC wrap-around at 2^XLEN
    redir(32'hFFFF_FFFC, 1'b0);
    idle();
    chk("pc_wrap", 64'(PC), 64'h0);

    // Async reset mid-fetch at 0x20
    redir(32'h20, 1'b0);
    chk("pre_reset_pc", 64'(PC), 64'h20);
    async_reset();

    // loaded_cnt saturation
    for (int i = 0; i < 258; i++) step(1, AW'(i), XLEN'(i), 0, 0, 0, '0, 0, 0);
    chk("cnt_saturate", 64'(loaded_cnt), 64'd256);
    step(1, 8'd5, 32'h55, 1, 0, 0, '0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
      end else begin
        step(($urandom_range(0, 1) == 1), AW'($urandom), $urandom,
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 4) == 0), $urandom,
             ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
